maze_round_ctrl: RTL and testbench

- Round sequencer for the maze game; owns the countdown timer block's reset and stop inputs.
- Decodes start/pause buttons and player goal events into a round state machine.
- Banks the remaining BCD seconds into a 3-digit BCD score on every win and tracks the level number.
- Sits between the input decode logic, the timer and the display/status logic.

---
 rtl/maze_round_ctrl_if.sv | 44 ++++
 rtl/maze_round_ctrl.sv | 177 +++++++++++++++++
 tb/tb_maze_round_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_round_ctrl_if.sv
// maze_round_ctrl_if
//   Groups the round controller's button, goal, timer and status signals.
//   Optional feature macro: MOVE_LIMIT_EN adds the moves_left status signal.
//   slave  : the round controller (consumes buttons/timer, drives status)
//   master : the surrounding logic (drives buttons/timer, reads status)
//   Signals:
//     btn_start, btn_pause : debounced synchronous buttons
//     at_goal, move_valid  : player events
//     timeout, time_bcd    : timer status, remaining seconds in 2-digit BCD
//     timer_rst, timer_stop: timer control
//     state, level, score, game_done (, moves_left): round status
interface maze_round_ctrl_if;
   logic        btn_start;
   logic        btn_pause;
   logic        at_goal;
   logic        move_valid;
   logic        timeout;
   logic [7:0]  time_bcd;
   logic        timer_rst;
   logic        timer_stop;
   logic [2:0]  state;
   logic [3:0]  level;
   logic [11:0] score;
   logic        game_done;
`ifdef MOVE_LIMIT_EN
   logic [7:0]  moves_left;
`endif

   modport slave (
      input  btn_start, btn_pause, at_goal, move_valid, timeout, time_bcd,
      output timer_rst, timer_stop, state, level, score, game_done
`ifdef MOVE_LIMIT_EN
      , output moves_left
`endif
   );

   modport master (
      output btn_start, btn_pause, at_goal, move_valid, timeout, time_bcd,
      input  timer_rst, timer_stop, state, level, score, game_done
`ifdef MOVE_LIMIT_EN
      , input moves_left
`endif
   );
endinterface

// File: rtl/maze_round_ctrl.sv
// maze_round_ctrl
//   Round sequencer for the maze game. Edge-detects start/pause, runs the
//   round FSM, owns the countdown timer's reset/stop, banks remaining BCD
//   seconds into a 3-digit BCD score on each win and tracks the level.
//   Optional feature macro: MOVE_LIMIT_EN (per-round move budget, moves_left).
//   Ports:
//     clk : system clock
//     rst : asynchronous reset, active-high
//     bus : maze_round_ctrl_if.slave (buttons, goal/move events, timer
//           status in; timer control and round status out, all registered)
module maze_round_ctrl #(
   parameter int unsigned HoldCycles = 50_000_000,
   parameter int unsigned MaxLevel   = 9,
   parameter int unsigned MaxMoves   = 99
) (
   input  logic                 clk,
   input  logic                 rst,
   maze_round_ctrl_if.slave     bus
);

   localparam int unsigned HoldW       = $clog2(HoldCycles + 1);
   localparam logic [HoldW-1:0] HoldLoad = HoldW'(HoldCycles);
   localparam logic [3:0]       MaxLvl   = 4'(MaxLevel);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StArm   = 3'd1,
      StRun   = 3'd2,
      StPause = 3'd3,
      StWin   = 3'd4,
      StLose  = 3'd5
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       level_q, level_d;
   logic [11:0]      score_q, score_d;
   logic             done_q, done_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic             start_q, pause_q;
   logic             timer_rst_q, timer_stop_q;
   logic             start_p, pause_p;
   logic             move_over;

   // 3-digit BCD + 2-digit BCD with per-digit decimal carry, saturating at 999.
   function automatic logic [11:0] bcd_add_sat(logic [11:0] a, logic [7:0] b);
      logic [4:0] d0, d1, d2;
      logic       c0, c1;
      d0 = {1'b0, a[3:0]} + {1'b0, b[3:0]};
      c0 = (d0 > 5'd9);
      if (c0) d0 = d0 - 5'd10;
      d1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, c0};
      c1 = (d1 > 5'd9);
      if (c1) d1 = d1 - 5'd10;
      d2 = {1'b0, a[11:8]} + {4'b0, c1};
      if (d2 > 5'd9) return 12'h999;
      return {d2[3:0], d1[3:0], d0[3:0]};
   endfunction

   assign start_p = bus.btn_start & ~start_q;
   assign pause_p = bus.btn_pause & ~pause_q;

`ifdef MOVE_LIMIT_EN
   localparam logic [8:0] MaxMoves9 = 9'(MaxMoves);
   localparam logic [7:0] MaxMoves8 = 8'(MaxMoves);

   logic [7:0] cnt_q, cnt_d;
   logic [7:0] moves_left_q, moves_left_d;

   assign move_over = bus.move_valid && (({1'b0, cnt_q} + 9'd1) > MaxMoves9);

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == StArm) begin
         cnt_d = 8'd0;
      end else if (state_q == StRun && bus.move_valid && cnt_q != 8'hFF) begin
         cnt_d = cnt_q + 8'd1;
      end
      moves_left_d = (cnt_d >= MaxMoves8) ? 8'd0 : MaxMoves8 - cnt_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= 8'd0;
         moves_left_q <= MaxMoves8;
      end else begin
         cnt_q        <= cnt_d;
         moves_left_q <= moves_left_d;
      end
   end

   assign bus.moves_left = moves_left_q;
`else
   assign move_over = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      score_d = score_q;
      done_d  = done_q;
      // Only ever non-zero in WIN/LOSE, so a free-running countdown is enough.
      hold_d  = (hold_q != '0) ? hold_q - 1'b1 : hold_q;
      unique case (state_q)
         StIdle: if (start_p) state_d = StArm;
         StArm:  state_d = StRun;
         StRun: begin
            if (bus.at_goal) begin
               state_d = StWin;
               score_d = bcd_add_sat(score_q, bus.time_bcd);
               if (level_q == MaxLvl) done_d = 1'b1;
               else                   level_d = level_q + 4'd1;
               hold_d  = HoldLoad;
            end else if (move_over || bus.timeout) begin
               state_d = StLose;
               hold_d  = HoldLoad;
            end else if (pause_p) begin
               state_d = StPause;
            end
         end
         StPause: begin
            if (start_p)      state_d = StArm;
            else if (pause_p) state_d = StRun;
         end
         StWin: begin
            if (start_p && hold_q == '0) begin
               state_d = StArm;
               if (done_q) begin
                  level_d = 4'd1;
                  score_d = 12'h000;
                  done_d  = 1'b0;
               end
            end
         end
         StLose: begin
            if (start_p && hold_q == '0) begin
               state_d = StArm;
               level_d = 4'd1;
               score_d = 12'h000;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         level_q      <= 4'd1;
         score_q      <= 12'h000;
         done_q       <= 1'b0;
         hold_q       <= '0;
         start_q      <= 1'b0;
         pause_q      <= 1'b0;
         timer_rst_q  <= 1'b1;
         timer_stop_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         level_q      <= level_d;
         score_q      <= score_d;
         done_q       <= done_d;
         hold_q       <= hold_d;
         start_q      <= bus.btn_start;
         pause_q      <= bus.btn_pause;
         // Timer controls follow the next state so they change with state.
         timer_rst_q  <= (state_d == StIdle) || (state_d == StArm);
         timer_stop_q <= (state_d != StRun);
      end
   end

   assign bus.state      = state_q;
   assign bus.level      = level_q;
   assign bus.score      = score_q;
   assign bus.game_done  = done_q;
   assign bus.timer_rst  = timer_rst_q;
   assign bus.timer_stop = timer_stop_q;

endmodule

// File: tb/tb_maze_round_ctrl.sv
// tb_maze_round_ctrl
//   Directed bench for maze_round_ctrl with a queue-based scoreboard and a
//   small behavioural model of state, level, score and game_done.
module tb_maze_round_ctrl;

   localparam int unsigned Hold = 4;
`ifdef MOVE_LIMIT_EN
   localparam int unsigned Moves = 3;
`else
   localparam int unsigned Moves = 99;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   maze_round_ctrl_if bus ();

   maze_round_ctrl #(
      .HoldCycles (Hold),
      .MaxLevel   (9),
      .MaxMoves   (Moves)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string       tag;
      int          sig;
      logic [11:0] exp;
   } item_t;

   item_t sb[$];
   int    vectors     = 0;
   int    miscompares = 0;

   int    m_state;
   int    m_level;
   int    m_score;
   logic  m_done;

   function automatic logic [11:0] obs(int sig);
      case (sig)
         0: return {9'd0, bus.state};
         1: return {11'd0, bus.timer_rst};
         2: return {11'd0, bus.timer_stop};
         3: return {8'd0, bus.level};
         4: return bus.score;
         5: return {11'd0, bus.game_done};
`ifdef MOVE_LIMIT_EN
         6: return {4'd0, bus.moves_left};
`endif
         default: return 12'hxxx;
      endcase
   endfunction

   function automatic logic [11:0] to_bcd(int v);
      logic [11:0] r;
      r[11:8] = 4'(v / 100);
      r[7:4]  = 4'((v / 10) % 10);
      r[3:0]  = 4'(v % 10);
      return r;
   endfunction

   function automatic int from_bcd(logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   task automatic push(string tag, int sig, logic [11:0] e);
      item_t it;
      it.tag = tag;
      it.sig = sig;
      it.exp = e;
      sb.push_back(it);
   endtask

   task automatic drain();
      item_t       it;
      logic [11:0] o;
      while (sb.size() > 0) begin
         it = sb.pop_front();
         o  = obs(it.sig);
         vectors++;
         assert (o === it.exp) else begin
            miscompares++;
            $display("FAIL %s sig%0d: observed %0h expected %0h", it.tag, it.sig, o, it.exp);
            $error("miscompare on %s", it.tag);
         end
      end
   endtask

   task automatic expect_model(string tag);
      push({tag, "_state"}, 0, 12'(m_state));
      push({tag, "_trst"},  1, (m_state == 0 || m_state == 1) ? 12'd1 : 12'd0);
      push({tag, "_tstop"}, 2, (m_state == 2) ? 12'd0 : 12'd1);
      push({tag, "_level"}, 3, 12'(m_level));
      push({tag, "_score"}, 4, to_bcd(m_score));
      push({tag, "_done"},  5, {11'd0, m_done});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(string tag);
      expect_model(tag);
      step();
      drain();
   endtask

   task automatic win(string tag, logic [7:0] t, logic to);
      bus.at_goal  = 1'b1;
      bus.timeout  = to;
      bus.time_bcd = t;
      m_state = 4;
      m_score = m_score + from_bcd(t);
      if (m_score > 999) m_score = 999;
      if (m_level == 9) m_done = 1'b1;
      else              m_level++;
      cycle(tag);
      bus.at_goal = 1'b0;
      bus.timeout = 1'b0;
   endtask

   task automatic lose(string tag);
      bus.timeout = 1'b1;
      m_state = 5;
      cycle(tag);
      bus.timeout = 1'b0;
   endtask

   // Start pulse during the hold is ignored; after the hold it arms a round.
   task automatic restart(string tag);
      bus.btn_start = 1'b1;
      cycle({tag, "_hold_ign"});
      bus.btn_start = 1'b0;
      for (int i = 0; i < 4; i++) cycle({tag, "_hold"});
      if (m_state == 5 || m_done) begin
         m_level = 1;
         m_score = 0;
         m_done  = 1'b0;
      end
      bus.btn_start = 1'b1;
      m_state = 1;
      cycle({tag, "_arm"});
      bus.btn_start = 1'b0;
      m_state = 2;
      cycle({tag, "_run"});
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.btn_start  = 1'b0;
      bus.btn_pause  = 1'b0;
      bus.at_goal    = 1'b0;
      bus.move_valid = 1'b0;
      bus.timeout    = 1'b0;
      bus.time_bcd   = 8'h00;
      rst = 1'b1;
      m_state = 0;
      m_level = 1;
      m_score = 0;
      m_done  = 1'b0;
      step();
`ifdef MOVE_LIMIT_EN
      push("reset_moves_left", 6, 12'(Moves));
`endif
      cycle("reset");
      rst = 1'b0;
      cycle("idle");

      // 1: start pulse walks IDLE -> ARM -> RUN
      bus.btn_start = 1'b1;
      m_state = 1;
      cycle("t1_arm");
      bus.btn_start = 1'b0;
      m_state = 2;
      cycle("t1_run");

      // 2: win banks time, hold then restart
      win("t2_win", 8'h17, 1'b0);
      restart("t2");

      // 3: saturation and digit carries from preloaded scores
      force dut.score_q = 12'h995;
      #1;
      release dut.score_q;
      m_score = 995;
      win("t3_sat", 8'h08, 1'b0);
      restart("t3a");
      force dut.score_q = 12'h089;
      #1;
      release dut.score_q;
      m_score = 89;
      win("t3_carry", 8'h16, 1'b0);
      restart("t3b");

      // 4: goal and timeout together wins; timeout alone loses
      win("t4_tie", 8'h05, 1'b1);
      restart("t4a");
      lose("t4_lose");
      restart("t4b");

      // 5: pause toggling, held level, start+pause in PAUSE
      bus.btn_pause = 1'b1;
      m_state = 3;
      cycle("t5_pause");
      cycle("t5_held1");
      cycle("t5_held2");
      bus.btn_pause = 1'b0;
      cycle("t5_rel");
      bus.btn_pause = 1'b1;
      m_state = 2;
      cycle("t5_resume");
      bus.btn_pause = 1'b0;
      cycle("t5_run");
      bus.btn_pause = 1'b1;
      m_state = 3;
      cycle("t5_pause2");
      bus.btn_pause = 1'b0;
      cycle("t5_paused");
      bus.btn_start = 1'b1;
      bus.btn_pause = 1'b1;
      m_state = 1;
      cycle("t5_both");
      bus.btn_start = 1'b0;
      bus.btn_pause = 1'b0;
      m_state = 2;
      cycle("t5_rerun");

      // 6: climb to MaxLevel, clear it, restart resets the game
      for (int i = 0; i < 8; i++) begin
         win("t6_climb", 8'h11, 1'b0);
         restart("t6_climb");
      end
      win("t6_final", 8'h20, 1'b0);
      restart("t6_reset");

`ifdef MOVE_LIMIT_EN
      push("t6_ml_start", 6, 12'(Moves));
      cycle("t6_ml_idle");
      for (int i = 1; i <= 3; i++) begin
         bus.move_valid = 1'b1;
         push("t6_ml_dec", 6, 12'(Moves - i));
         cycle("t6_move");
         bus.move_valid = 1'b0;
         cycle("t6_gap");
      end
      bus.move_valid = 1'b1;
      m_state = 5;
      push("t6_ml_zero", 6, 12'd0);
      cycle("t6_move_lose");
      bus.move_valid = 1'b0;
`else
      for (int i = 0; i < 4; i++) begin
         bus.move_valid = 1'b1;
         cycle("t6_move_ign");
         bus.move_valid = 1'b0;
         cycle("t6_gap");
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
